xadc_drp_responder: RTL and testbench
=====================================

# xadc_drp_responder

Behavioural stand-in for the XADC DRP port: it answers DRP reads and writes and generates end-of-conversion pulses from an injected 12-bit sample stream. It sits on the far side of the XADC single-channel wrapper, replacing the hard macro in simulation and loopback builds. The wrapper-side DRP signals connect to it unchanged, and upstream test logic supplies samples. One conversion slot is modelled on auxiliary channel 5 (result register 7'h15).

## Interface
- CONV_PERIOD, 100: cycles between successive eoc pulses (legal ≥ 4).
- BUSY_CYCLES, 26: cycles busy_o is high before each eoc (legal 1..CONV_PERIOD-1).
- READ_LATENCY, 2: cycles from den_i to drdy_o (legal 1..8).
- RESULT_ADDR, 7'h15: DRP address of the conversion result register.
- CFG_ADDR, 7'h41: DRP address of the read/write config register.

- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- den_i  in  1  DRP enable, one-cycle strobe.
- dwe_i  in  1  DRP write enable, qualified by den_i.
- daddr_i  in  7  DRP address, qualified by den_i.
- di_i  in  16  DRP write data, qualified by den_i & dwe_i.
- drdy_o  out  1  DRP ready, one-cycle pulse.
- do_o  out  16  DRP read data; valid only while drdy_o, 16'h0000 otherwise.
- sample_i  in  12  next conversion value.
- sample_valid_i  in  1  sample_i is valid.
- sample_ready_o  out  1  high on the eoc cycle; sample consumed when sample_valid_i is also high.
- eoc_o  out  1  end-of-conversion pulse.
- channel_o  out  5  5'h15 on eoc cycles, 5'h00 otherwise.
- busy_o  out  1  conversion in progress.
- missed_o  out  1  sticky: an eoc occurred without sample_valid_i.
- proto_err_o  out  1  sticky: den_i arrived while a transaction was pending.

## Operation
- Conversion timer counts 0..CONV_PERIOD-1, then wraps to 0. eoc_o, sample_ready_o and channel_o=5'h15 are asserted when the count equals CONV_PERIOD-1.
- busy_o is high when the count is in [CONV_PERIOD-1-BUSY_CYCLES, CONV_PERIOD-2]. It is low on the eoc cycle.
- On the eoc cycle, if sample_valid_i is high, result_reg ← {sample_i, 4'h0}. Otherwise result_reg holds and missed_o sets.
- DRP transaction:
  - den_i accepted when idle.
  - Read returns result_reg for RESULT_ADDR, cfg_reg for CFG_ADDR, and 16'h0000 for any other address.
  - Write to CFG_ADDR stores di_i into cfg_reg. Writes elsewhere are acknowledged and discarded.
  - Writes to RESULT_ADDR are ignored.
- Read data is snapshotted at the den_i cycle. If den_i coincides with an eoc that updates result_reg, the new value is returned (forwarded). This supports den tied to eoc.
- One outstanding transaction at a time. den_i while pending is dropped (no drdy_o generated) and sets proto_err_o. The pending transaction completes normally.
- Write to CFG_ADDR takes effect at the den_i edge. A read of CFG_ADDR in the same cycle as a write is impossible (single port).
- missed_o and proto_err_o clear only on rst.

## Timing
- Reset values:
  - All outputs 0, do_o 16'h0000, channel_o 5'h00.
  - result_reg 16'h0000, cfg_reg 16'h0000, timer 0, no pending transaction.
- First eoc_o occurs CONV_PERIOD-1 cycles after the first cycle with rst low. Thereafter eoc_o repeats every CONV_PERIOD cycles.
- den_i sampled high at cycle t → drdy_o high for exactly cycle t+READ_LATENCY, with do_o valid in that cycle.
- Next den_i is accepted at t+READ_LATENCY (same cycle as drdy_o). Earlier arrivals are errors.
- rst mid-transaction aborts it: no drdy_o follows, and timer and registers return to reset values.
- do_o is registered (no combinational path from daddr_i).

## Test plan
- Reset, feed sample_i=12'hABC constantly valid; den_i tied to eoc_o, daddr_i=7'h15 → first eoc at cycle 99, drdy_o at cycle 101 with do_o=16'hABC0, repeating every 100 cycles.
- Write di_i=16'h1234 to 7'h41, then read 7'h41 → drdy_o 2 cycles after each den_i; read returns 16'h1234. Read of 7'h20 returns 16'h0000.
- Hold sample_valid_i low across one eoc → missed_o rises on the cycle after that eoc and stays high. Read of 7'h15 returns the previous value.
- Issue den_i at t and t+1 → single drdy_o at t+2; proto_err_o high from t+2 onward.
- Assert rst one cycle after a den_i → no drdy_o; all outputs 0. Timer restarts, so the next eoc is 99 cycles after rst deasserts.
- Sweep READ_LATENCY=1 and 8, CONV_PERIOD=4, BUSY_CYCLES=1 → drdy_o latency and eoc spacing match; busy_o high only on count 2.

Source files
------------

// File: rtl/xadc_drp_responder.sv
// Behavioural stand-in for the XADC DRP port. Answers DRP reads and writes with a fixed
// read latency and produces periodic end-of-conversion pulses carrying injected samples
// on auxiliary channel 5.
module xadc_drp_responder #(
    parameter int unsigned CONV_PERIOD  = 100,
    parameter int unsigned BUSY_CYCLES  = 26,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [6:0]  RESULT_ADDR  = 7'h15,
    parameter logic [6:0]  CFG_ADDR     = 7'h41
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        den_i,
    input  logic        dwe_i,
    input  logic [6:0]  daddr_i,
    input  logic [15:0] di_i,
    output logic        drdy_o,
    output logic [15:0] do_o,
    input  logic [11:0] sample_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    output logic        eoc_o,
    output logic [4:0]  channel_o,
    output logic        busy_o,
    output logic        missed_o,
    output logic        proto_err_o
);

    localparam int unsigned TW      = (CONV_PERIOD > 2) ? $clog2(CONV_PERIOD) : 1;
    localparam logic [TW-1:0] TLast  = TW'(CONV_PERIOD - 1);
    localparam logic [TW-1:0] BusyLo = TW'(CONV_PERIOD - 1 - BUSY_CYCLES);
    localparam logic [TW-1:0] BusyHi = TW'(CONV_PERIOD - 2);
    localparam logic [3:0]    LatInit = 4'(READ_LATENCY - 1);
    localparam logic [4:0]    AuxChannel = 5'h15;

    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   result_q, result_d;
    logic [15:0]   cfg_q, cfg_d;
    logic          missed_q, missed_d;
    logic          perr_q, perr_d;
    logic          pend_q, pend_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   snap_q, snap_d;
    logic          drdy_q, drdy_d;
    logic [15:0]   do_q, do_d;

    logic          eoc;
    logic [15:0]   rd_data;

    assign eoc = (timer_q == TLast);

    // Conversion timer and result capture on each end of conversion.
    always_comb begin
        timer_d  = eoc ? '0 : timer_q + 1'b1;
        result_d = result_q;
        missed_d = missed_q;
        if (eoc) begin
            if (sample_valid_i) begin
                result_d = {sample_i, 4'h0};
            end else begin
                missed_d = 1'b1;
            end
        end
    end

    // Read mux uses result_d so a read coinciding with an updating eoc sees the new sample.
    always_comb begin
        rd_data = 16'h0000;
        if (!dwe_i) begin
            if (daddr_i == RESULT_ADDR) begin
                rd_data = result_d;
            end else if (daddr_i == CFG_ADDR) begin
                rd_data = cfg_q;
            end
        end
    end

    // DRP transaction sequencing: one outstanding request, fixed latency to drdy.
    always_comb begin
        cfg_d  = cfg_q;
        perr_d = perr_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        snap_d = snap_q;
        drdy_d = 1'b0;
        do_d   = 16'h0000;

        if (pend_q) begin
            if (den_i) begin
                perr_d = 1'b1;
            end
            if (cnt_q == 4'd1) begin
                drdy_d = 1'b1;
                do_d   = snap_q;
                pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (den_i) begin
            if (dwe_i && (daddr_i == CFG_ADDR)) begin
                cfg_d = di_i;
            end
            if (READ_LATENCY == 1) begin
                drdy_d = 1'b1;
                do_d   = rd_data;
            end else begin
                pend_d = 1'b1;
                cnt_d  = LatInit;
                snap_d = rd_data;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= '0;
            result_q <= 16'h0000;
            cfg_q    <= 16'h0000;
            missed_q <= 1'b0;
            perr_q   <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= 4'd0;
            snap_q   <= 16'h0000;
            drdy_q   <= 1'b0;
            do_q     <= 16'h0000;
        end else begin
            timer_q  <= timer_d;
            result_q <= result_d;
            cfg_q    <= cfg_d;
            missed_q <= missed_d;
            perr_q   <= perr_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            drdy_q   <= drdy_d;
            do_q     <= do_d;
        end
    end

    // Output decode.
    always_comb begin
        eoc_o          = eoc;
        sample_ready_o = eoc;
        channel_o      = eoc ? AuxChannel : 5'h00;
        busy_o         = (timer_q >= BusyLo) && (timer_q <= BusyHi);
        missed_o       = missed_q;
        proto_err_o    = perr_q;
        drdy_o         = drdy_q;
        do_o           = do_q;
    end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Self-checking bench for xadc_drp_responder: DRP responses are scoreboarded by due cycle
// and data; conversion timing, sticky flags, reset abort and parameter sweep are checked
// inline by the scenario tasks.
module tb_xadc_drp_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Main DUT
    logic        rst = 1'b1;
    logic        tie = 1'b0;
    logic        den_drv = 1'b0;
    logic        den, dwe = 1'b0;
    logic [6:0]  daddr = 7'h00;
    logic [15:0] di = 16'h0000;
    logic [11:0] sample = 12'h000;
    logic        sample_valid = 1'b0;
    logic        drdy, sample_ready, eoc, busy, missed, proto_err;
    logic [15:0] dout;
    logic [4:0]  channel;

    assign den = tie ? eoc : den_drv;

    xadc_drp_responder u_dut (
        .clk(clk), .rst(rst), .den_i(den), .dwe_i(dwe), .daddr_i(daddr), .di_i(di),
        .drdy_o(drdy), .do_o(dout), .sample_i(sample), .sample_valid_i(sample_valid),
        .sample_ready_o(sample_ready), .eoc_o(eoc), .channel_o(channel), .busy_o(busy),
        .missed_o(missed), .proto_err_o(proto_err)
    );

    // Sweep DUTs: short period, latency 1 and 8, shared stimulus
    logic        rst2 = 1'b1;
    logic        den2 = 1'b0;
    logic [6:0]  addr2 = 7'h15;
    logic        a_drdy, a_rdy, a_eoc, a_busy, a_missed, a_perr;
    logic        b_drdy, b_rdy, b_eoc, b_busy, b_missed, b_perr;
    logic [15:0] a_do, b_do;
    logic [4:0]  a_ch, b_ch;

    xadc_drp_responder #(.CONV_PERIOD(4), .BUSY_CYCLES(1), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst2), .den_i(den2), .dwe_i(1'b0), .daddr_i(addr2), .di_i(16'h0000),
        .drdy_o(a_drdy), .do_o(a_do), .sample_i(12'h5A5), .sample_valid_i(1'b1),
        .sample_ready_o(a_rdy), .eoc_o(a_eoc), .channel_o(a_ch), .busy_o(a_busy),
        .missed_o(a_missed), .proto_err_o(a_perr)
    );

    xadc_drp_responder #(.CONV_PERIOD(4), .BUSY_CYCLES(1), .READ_LATENCY(8)) u_dut_b (
        .clk(clk), .rst(rst2), .den_i(den2), .dwe_i(1'b0), .daddr_i(addr2), .di_i(16'h0000),
        .drdy_o(b_drdy), .do_o(b_do), .sample_i(12'h5A5), .sample_valid_i(1'b1),
        .sample_ready_o(b_rdy), .eoc_o(b_eoc), .channel_o(b_ch), .busy_o(b_busy),
        .missed_o(b_missed), .proto_err_o(b_perr)
    );

    // Scoreboard of expected DRP responses
    typedef struct {
        int          due;
        logic [15:0] data;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    function automatic void push_exp(input int due, input logic [15:0] data, input bit chk);
        exp_t e;
        e.due  = due;
        e.data = data;
        e.chk  = chk;
        sb.push_back(e);
    endfunction

    // Response monitor: every drdy must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (drdy) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL drdy_unexpected: drdy at cycle %0d, none pending", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.due) begin
                    n_fail++;
                    $display("FAIL drdy_cycle: got cycle %0d, expected %0d", cyc, e.due);
                end
                if (e.chk) begin
                    n_checks++;
                    if (dout !== e.data) begin
                        n_fail++;
                        $display("FAIL drdy_data: got %h, expected %h", dout, e.data);
                    end
                end
            end
        end else if (dout !== 16'h0000) begin
            n_checks++;
            n_fail++;
            $display("FAIL do_idle: got %h while drdy low, expected 0000", dout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_eoc(input int bound, output bit found);
        found = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (eoc) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_drained(input string name);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d responses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    int r0;

    task automatic test_reset();
        rst = 1'b1;
        sample = 12'hABC;
        sample_valid = 1'b1;
        daddr = 7'h15;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({drdy, dout, eoc, sample_ready, channel, busy, missed, proto_err} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got drdy=%b do=%h eoc=%b rdy=%b ch=%h busy=%b miss=%b perr=%b, expected all 0",
                     drdy, dout, eoc, sample_ready, channel, busy, missed, proto_err);
        end
        tick();
        rst = 1'b0;
        r0 = cyc;
    endtask

    task automatic test_eoc_loop();
        int busy_cnt = 0;
        bit found;
        tie = 1'b1;
        daddr = 7'h15;
        dwe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            found = 1'b0;
            for (int k = 0; k < 150; k++) begin
                @(negedge clk);
                if (eoc) begin
                    found = 1'b1;
                    break;
                end
                if (busy) busy_cnt++;
            end
            n_checks++;
            if (!found || cyc != r0 + 99 + 100 * i) begin
                n_fail++;
                $display("FAIL eoc_cycle[%0d]: found=%0b at cycle %0d, expected %0d",
                         i, found, cyc, r0 + 99 + 100 * i);
            end
            if (found) begin
                push_exp(cyc + 2, 16'hABC0, 1'b1);
                n_checks++;
                if (channel !== 5'h15 || sample_ready !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL eoc_outputs: got ch=%h rdy=%b busy=%b, expected 15 1 0",
                             channel, sample_ready, busy);
                end
            end
            if (i == 0) begin
                n_checks++;
                if (busy_cnt != 26) begin
                    n_fail++;
                    $display("FAIL busy_len: got %0d busy cycles, expected 26", busy_cnt);
                end
            end
        end
        tick();
        tie = 1'b0;
        repeat (3) tick();
        expect_drained("eoc_loop");
    endtask

    task automatic test_cfg();
        tick();
        den_drv = 1'b1; dwe = 1'b1; daddr = 7'h41; di = 16'h1234;
        push_exp(cyc + 2, 16'h0000, 1'b0);
        tick();
        den_drv = 1'b0; dwe = 1'b0;
        tick();
        den_drv = 1'b1; daddr = 7'h41;
        push_exp(cyc + 2, 16'h1234, 1'b1);
        tick();
        den_drv = 1'b0;
        tick();
        den_drv = 1'b1; daddr = 7'h20;
        push_exp(cyc + 2, 16'h0000, 1'b1);
        tick();
        den_drv = 1'b0;
        repeat (3) tick();
        expect_drained("cfg");
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_no_proto_err: got %b, expected 0", proto_err);
        end
    endtask

    task automatic test_missed();
        bit found;
        wait_eoc(120, found);
        n_checks++;
        if (!found || missed !== 1'b0) begin
            n_fail++;
            $display("FAIL missed_pre: found=%0b missed=%b, expected 1 0", found, missed);
        end
        tick();
        sample_valid = 1'b0;
        wait_eoc(120, found);
        n_checks++;
        if (!found || missed !== 1'b0) begin
            n_fail++;
            $display("FAIL missed_at_eoc: found=%0b missed=%b, expected 1 0", found, missed);
        end
        @(negedge clk);
        n_checks++;
        if (missed !== 1'b1) begin
            n_fail++;
            $display("FAIL missed_rise: got %b, expected 1", missed);
        end
        tick();
        sample_valid = 1'b1;
        sample = 12'h123;
        den_drv = 1'b1; daddr = 7'h15;
        push_exp(cyc + 2, 16'hABC0, 1'b1);
        tick();
        den_drv = 1'b0;
        wait_eoc(120, found);
        @(negedge clk);
        n_checks++;
        if (!found || missed !== 1'b1) begin
            n_fail++;
            $display("FAIL missed_sticky: found=%0b missed=%b, expected 1 1", found, missed);
        end
        tick();
        den_drv = 1'b1; daddr = 7'h15;
        push_exp(cyc + 2, 16'h1230, 1'b1);
        tick();
        den_drv = 1'b0;
        repeat (3) tick();
        expect_drained("missed");
    endtask

    task automatic test_back_to_back();
        int t;
        tick();
        den_drv = 1'b1; daddr = 7'h41; dwe = 1'b0;
        t = cyc;
        push_exp(t + 2, 16'h1234, 1'b1);
        tick();
        daddr = 7'h20;
        @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_early: got %b at t+1, expected 0", proto_err);
        end
        tick();
        den_drv = 1'b0;
        @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_rise: got %b at t+2, expected 1", proto_err);
        end
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_sticky: got %b, expected 1", proto_err);
        end
        expect_drained("back_to_back");
    endtask

    task automatic test_rst_abort();
        bit found;
        int r;
        tick();
        den_drv = 1'b1; daddr = 7'h41;
        tick();
        den_drv = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({drdy, dout, eoc, sample_ready, channel, busy, missed, proto_err} !== 28'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got drdy=%b do=%h eoc=%b rdy=%b ch=%h busy=%b miss=%b perr=%b, expected all 0",
                     drdy, dout, eoc, sample_ready, channel, busy, missed, proto_err);
        end
        tick();
        rst = 1'b0;
        r = cyc;
        wait_eoc(120, found);
        n_checks++;
        if (!found || cyc != r + 99) begin
            n_fail++;
            $display("FAIL abort_eoc_cycle: found=%0b at %0d, expected %0d", found, cyc, r + 99);
        end
        n_checks++;
        if (missed !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_missed_clear: got %b, expected 0", missed);
        end
        tick();
        den_drv = 1'b1; daddr = 7'h41;
        push_exp(cyc + 2, 16'h0000, 1'b1);
        tick();
        den_drv = 1'b0;
        repeat (3) tick();
        expect_drained("rst_abort");
    endtask

    task automatic test_sweep();
        int r;
        int t;
        int ph;
        tick();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        r = cyc;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            ph = (cyc - r) % 4;
            n_checks++;
            if (a_eoc !== (ph == 3) || b_eoc !== (ph == 3) ||
                a_busy !== (ph == 2) || b_busy !== (ph == 2)) begin
                n_fail++;
                $display("FAIL sweep_timer: count %0d got eoc=%b/%b busy=%b/%b, expected eoc=%0b busy=%0b",
                         ph, a_eoc, b_eoc, a_busy, b_busy, ph == 3, ph == 2);
            end
        end
        tick();
        den2 = 1'b1;
        t = cyc;
        tick();
        den2 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_drdy !== (cyc == t + 1) || b_drdy !== (cyc == t + 8)) begin
                n_fail++;
                $display("FAIL sweep_latency: t+%0d got drdy=%b/%b, expected %0b/%0b",
                         cyc - t, a_drdy, b_drdy, cyc == t + 1, cyc == t + 8);
            end
            n_checks++;
            if (a_do !== (a_drdy ? 16'h5A50 : 16'h0000) ||
                b_do !== (b_drdy ? 16'h5A50 : 16'h0000)) begin
                n_fail++;
                $display("FAIL sweep_data: t+%0d got do=%h/%h, expected 5A50 when ready",
                         cyc - t, a_do, b_do);
            end
            if (k < 9) tick();
        end
    endtask

    initial begin
        test_reset();
        test_eoc_loop();
        test_cfg();
        test_missed();
        test_back_to_back();
        test_rst_abort();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
